// File: rtl/voice_mixer_pkg.sv
// Shared types, constants and helpers for the voice mixer.
// The VOICE_RAMP_EN macro (see voice_mixer.sv) enables per-voice gain slewing.
package voice_mixer_pkg;

  localparam int unsigned NUM_VOICES = 8;
  localparam int unsigned FRAC_BITS  = 20;
  localparam int unsigned PHASE_W    = 40;
  localparam int unsigned Q20_W      = 32;
  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned ACC_W      = 17;
  localparam int unsigned VIDX_W     = 3;

  localparam int unsigned DEF_SAMPLE_RATE = 48000;
  localparam int unsigned DEF_VOICE_AMP   = 4095;
  localparam int unsigned DEF_RAMP_STEP   = 1 << 12;

  typedef logic signed [SAMPLE_W-1:0] sample_t;
  typedef logic        [PHASE_W-1:0]  phase_t;
  typedef logic        [Q20_W-1:0]    q20_t;
  typedef logic signed [ACC_W-1:0]    acc_t;

  typedef enum logic [1:0] {IDLE, ACCUM, OUTPUT} state_t;

  localparam q20_t UNITY = Q20_W'(1) << FRAC_BITS;

  // Saturate the 17-bit accumulator into the 16-bit output range.
  function automatic sample_t sat16(input acc_t a);
    if (a > 17'sd32767)       return 16'sh7fff;
    else if (a < -17'sd32768) return 16'sh8000;
    else                      return SAMPLE_W'(a);
  endfunction

  // Clamp a signed Q.20 volume into [0, unity].
  function automatic q20_t clamp_gain(input q20_t v);
    if (v[Q20_W-1])     return '0;
    else if (v > UNITY) return UNITY;
    else                return v;
  endfunction

endpackage

// File: rtl/voice_gain_ramp.sv
// Per-voice gain slew: moves toward the target by at most RAMP_STEP per accepted sample tick.
module voice_gain_ramp
  import voice_mixer_pkg::*;
#(
  parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
) (
  input  logic clk,
  input  logic reset,
  input  logic step,
  input  q20_t target,
  output q20_t gain
);

  localparam q20_t STEP = Q20_W'(RAMP_STEP);

  // Linear attack/release toward the clamped volume.
  always_ff @(posedge clk) begin
    if (reset) begin
      gain <= '0;
    end else if (step) begin
      if (gain < target) begin
        gain <= ((target - gain) > STEP) ? gain + STEP : target;
      end else if (gain > target) begin
        gain <= ((gain - target) > STEP) ? gain - STEP : target;
      end
    end
  end

endmodule

// File: rtl/voice_mixer.sv
// Time-multiplexed 8-voice square-wave mixer producing one signed 16-bit sample per tick.
// Optional macro VOICE_RAMP_EN: ramped per-voice gain instead of the raw snapshot volume.
module voice_mixer
  import voice_mixer_pkg::*;
#(
  parameter int unsigned SAMPLE_RATE = DEF_SAMPLE_RATE,
  parameter int unsigned VOICE_AMP   = DEF_VOICE_AMP
`ifdef VOICE_RAMP_EN
  , parameter int unsigned RAMP_STEP = DEF_RAMP_STEP
`endif
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sample_tick,
  input  logic [31:0]        frequencies   [NUM_VOICES-1:0],
  input  logic [31:0]        voice_volumes [NUM_VOICES-1:0],
  output logic signed [15:0] sample_out,
  output logic               sample_valid,
  output logic               busy,
  output logic               overrun
);

  localparam phase_t PERIOD = PHASE_W'(SAMPLE_RATE) << FRAC_BITS;
  localparam phase_t HALF   = PERIOD >> 1;
  localparam int unsigned PROD_W = PHASE_W + 8;

  state_t              state;
  logic [VIDX_W-1:0]   v;
  acc_t                acc;
  q20_t                freq_snap [NUM_VOICES];
  phase_t              phase     [NUM_VOICES];
  q20_t                cur_gain;

  logic                accept_c;
  logic                silent_c;
  logic [PROD_W-1:0]   prod_c;
  acc_t                amp_c;
  acc_t                contrib_c;
  phase_t              phase_sum_c;
  phase_t              phase_nxt_c;

  assign accept_c = (state == IDLE) && sample_tick;

`ifdef VOICE_RAMP_EN
  q20_t gains [NUM_VOICES];

  for (genvar gi = 0; gi < NUM_VOICES; gi++) begin : g_ramp
    voice_gain_ramp #(.RAMP_STEP(RAMP_STEP)) u_ramp (
      .clk    (clk),
      .reset  (reset),
      .step   (accept_c),
      .target (clamp_gain(voice_volumes[gi])),
      .gain   (gains[gi])
    );
  end

  assign cur_gain = gains[v];
`else
  q20_t vol_snap [NUM_VOICES];

  assign cur_gain = vol_snap[v];
`endif

  // Per-voice datapath for the voice currently selected by v.
  always_comb begin
    silent_c    = 1'b0;
    prod_c      = '0;
    amp_c       = '0;
    contrib_c   = '0;
    phase_sum_c = '0;
    phase_nxt_c = '0;

    silent_c    = (freq_snap[v] == '0) || (PHASE_W'(freq_snap[v]) >= HALF);
    prod_c      = PROD_W'(VOICE_AMP) * PROD_W'(cur_gain);
    amp_c       = ACC_W'(prod_c >> FRAC_BITS);
    phase_sum_c = phase[v] + PHASE_W'(freq_snap[v]);

    if (!silent_c) begin
      contrib_c   = (phase[v] < HALF) ? amp_c : -amp_c;
      phase_nxt_c = (phase_sum_c >= PERIOD) ? phase_sum_c - PERIOD : phase_sum_c;
    end
  end

  // Mix sequencer: snapshot on tick, accumulate one voice per clock, then publish.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      v            <= '0;
      acc          <= '0;
      sample_out   <= '0;
      sample_valid <= 1'b0;
      busy         <= 1'b0;
      overrun      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        phase[i]     <= '0;
        freq_snap[i] <= '0;
`ifndef VOICE_RAMP_EN
        vol_snap[i]  <= '0;
`endif
      end
    end else begin
      sample_valid <= 1'b0;
      if (sample_tick && (state != IDLE)) overrun <= 1'b1;

      case (state)
        IDLE: begin
          if (sample_tick) begin
            for (int i = 0; i < NUM_VOICES; i++) begin
              freq_snap[i] <= frequencies[i];
`ifndef VOICE_RAMP_EN
              vol_snap[i]  <= clamp_gain(voice_volumes[i]);
`endif
            end
            acc   <= '0;
            v     <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          acc      <= acc + contrib_c;
          phase[v] <= phase_nxt_c;
          v        <= v + VIDX_W'(1);
          if (v == VIDX_W'(NUM_VOICES - 1)) state <= OUTPUT;
        end
        OUTPUT: begin
          sample_out   <= sat16(acc);
          sample_valid <= 1'b1;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_mixer.sv
// Directed self-checking bench for voice_mixer.
// Runs the DUT at an 8 kHz sample rate: a Q12.20 frequency cannot exceed 4096 Hz,
// so quarter-rate (2000 Hz), eighth-rate (1000 Hz) and Nyquist (4000 Hz) stay representable.
module tb_voice_mixer;

  localparam int unsigned SR   = 8000;
  localparam logic [31:0] ONE  = 32'h0010_0000;
  localparam logic [31:0] F_Q  = 32'd2000 << 20;
  localparam logic [31:0] F_E  = 32'd1000 << 20;
  localparam logic [31:0] F_NY = 32'd4000 << 20;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               sample_tick = 1'b0;
  logic [31:0]        freqs [8];
  logic [31:0]        vols  [8];
  logic signed [15:0] sample_out;
  logic               sample_valid;
  logic               busy;
  logic               overrun;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  voice_mixer #(
    .SAMPLE_RATE (SR),
    .VOICE_AMP   (4095)
`ifdef VOICE_RAMP_EN
    , .RAMP_STEP (1 << 18)
`endif
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .sample_tick   (sample_tick),
    .frequencies   (freqs),
    .voice_volumes (vols),
    .sample_out    (sample_out),
    .sample_valid  (sample_valid),
    .busy          (busy),
    .overrun       (overrun)
  );

  task automatic set_all(input logic [31:0] f, input logic [31:0] vol);
    for (int i = 0; i < 8; i++) begin
      freqs[i] = f;
      vols[i]  = vol;
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issue one tick and wait (bounded) for sample_valid; lat counts edges from the capture edge.
  task automatic run_tick(output logic signed [15:0] s, output int lat);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    lat = 1;
    while (sample_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sample_out;
  endtask

  task automatic test_reset();
    set_all('0, '0);
    pulse_reset();
    checks += 4;
    if (sample_out !== 16'sd0)  begin errors++; $display("FAIL reset_sample got=%0d exp=0", sample_out); end
    if (sample_valid !== 1'b0)  begin errors++; $display("FAIL reset_valid got=%b exp=0", sample_valid); end
    if (busy !== 1'b0)          begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (overrun !== 1'b0)       begin errors++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_silent();
    logic signed [15:0] s;
    int lat;
    set_all(F_Q, '0);
    for (int k = 0; k < 3; k++) begin
      run_tick(s, lat);
      checks += 3;
      if (lat !== 10)  begin errors++; $display("FAIL silent_latency tick=%0d got=%0d exp=10", k, lat); end
      if (s !== 16'sd0) begin errors++; $display("FAIL silent_sample tick=%0d got=%0d exp=0", k, s); end
      @(posedge clk); #1;
      if (sample_valid !== 1'b0) begin errors++; $display("FAIL silent_valid_width tick=%0d got=%b exp=0", k, sample_valid); end
    end
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL silent_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_single_voice();
    logic signed [15:0] s;
    logic signed [15:0] exp_s;
    int lat;
    pulse_reset();
    set_all('0, '0);
    freqs[0] = F_Q;
    vols[0]  = ONE;
    for (int k = 0; k < 8; k++) begin
      exp_s = ((k % 4) < 2) ? 16'sd4095 : -16'sd4095;
      run_tick(s, lat);
      checks++;
      if (s !== exp_s) begin errors++; $display("FAIL single_voice tick=%0d got=%0d exp=%0d", k, s, exp_s); end
    end
  endtask

  task automatic test_all_voices();
    logic signed [15:0] s;
    logic signed [15:0] exp_s [3];
    int lat;
    exp_s[0] = 16'sd32760;
    exp_s[1] = 16'sd32760;
    exp_s[2] = -16'sd32760;
    pulse_reset();
    set_all(F_Q, ONE);
    for (int k = 0; k < 3; k++) begin
      run_tick(s, lat);
      checks++;
      if (s !== exp_s[k]) begin errors++; $display("FAIL all_voices tick=%0d got=%0d exp=%0d", k, s, exp_s[k]); end
    end
  endtask

  task automatic test_clamp();
    logic signed [15:0] s;
    int lat;
    pulse_reset();
    set_all('0, '0);
    freqs[0] = F_Q;
    vols[0]  = 32'd2 << 20;
    run_tick(s, lat);
    checks++;
    if (s !== 16'sd4095) begin errors++; $display("FAIL over_range_volume got=%0d exp=4095", s); end
    vols[0] = 32'hFFF0_0000;
    run_tick(s, lat);
    checks++;
    if (s !== 16'sd0) begin errors++; $display("FAIL negative_volume got=%0d exp=0", s); end
  endtask

  task automatic test_nyquist();
    logic signed [15:0] s;
    int lat;
    pulse_reset();
    set_all('0, '0);
    freqs[0] = F_Q;
    vols[0]  = ONE;
    run_tick(s, lat);
    freqs[0] = F_NY;
    for (int k = 0; k < 2; k++) begin
      run_tick(s, lat);
      checks++;
      if (s !== 16'sd0) begin errors++; $display("FAIL nyquist tick=%0d got=%0d exp=0", k, s); end
    end
    // Phase was forced to zero, so the next quarter-rate sample starts positive.
    freqs[0] = F_Q;
    run_tick(s, lat);
    checks++;
    if (s !== 16'sd4095) begin errors++; $display("FAIL nyquist_phase_cleared got=%0d exp=4095", s); end
  endtask

  task automatic test_mid_mix_change();
    logic signed [15:0] s;
    int lat;
    pulse_reset();
    set_all('0, '0);
    freqs[0] = F_Q;
    vols[0]  = ONE;
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (2) @(posedge clk);
    #1 vols[0] = '0;
    freqs[0] = '0;
    lat = 3;
    while (sample_valid !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    s = sample_out;
    checks += 2;
    if (lat !== 10)       begin errors++; $display("FAIL mid_mix_latency got=%0d exp=10", lat); end
    if (s !== 16'sd4095)  begin errors++; $display("FAIL mid_mix_change got=%0d exp=4095", s); end
  endtask

  task automatic test_overrun();
    int valids;
    pulse_reset();
    set_all(F_Q, ONE);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    valids = 0;
    for (int c = 0; c < 25; c++) begin
      if (sample_valid === 1'b1) valids++;
      @(posedge clk); #1;
    end
    checks += 2;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got=%b exp=1", overrun); end
    if (valids !== 1)     begin errors++; $display("FAIL overrun_valid_count got=%0d exp=1", valids); end
    pulse_reset();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got=%b exp=0", overrun); end
  endtask

  task automatic test_reset_mid_mix();
    int valids;
    pulse_reset();
    set_all(F_Q, ONE);
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy); end
    valids = 0;
    for (int c = 0; c < 15; c++) begin
      if (sample_valid === 1'b1) valids++;
      @(posedge clk); #1;
    end
    checks++;
    if (valids !== 0) begin errors++; $display("FAIL abort_valid_count got=%0d exp=0", valids); end
  endtask

`ifdef VOICE_RAMP_EN
  task automatic test_ramp();
    logic signed [15:0] s;
    logic signed [15:0] exp_s [8];
    int lat;
    exp_s[0] = 16'sd1023;
    exp_s[1] = 16'sd2047;
    exp_s[2] = 16'sd3071;
    exp_s[3] = 16'sd4095;
    exp_s[4] = -16'sd4095;
    exp_s[5] = -16'sd4095;
    exp_s[6] = -16'sd4095;
    exp_s[7] = -16'sd4095;
    pulse_reset();
    set_all('0, '0);
    freqs[0] = F_E;
    vols[0]  = ONE;
    for (int k = 0; k < 8; k++) begin
      run_tick(s, lat);
      checks++;
      if (s !== exp_s[k]) begin errors++; $display("FAIL ramp tick=%0d got=%0d exp=%0d", k, s, exp_s[k]); end
    end
  endtask
`endif

  initial begin
    set_all('0, '0);
    test_reset();
    test_silent();
`ifdef VOICE_RAMP_EN
    test_ramp();
`else
    test_single_voice();
    test_all_voices();
    test_clamp();
    test_nyquist();
    test_mid_mix_change();
`endif
    test_overrun();
    test_reset_mid_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
